reg_sel_sequencer: RTL and testbench

- Parametrised register-select unit for the processor datapath.
- Decodes a read address into a registered one-hot bus-drive select.
- Decodes a write address into a timed one-hot write-enable strobe under a four-phase req/ack handshake.
- Flags invalid addresses and read/write collisions; replaces the purely combinational register decoder in the control path.

---
 rtl/reg_sel_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reg_sel_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_sel_sequencer.sv
// reg_sel_sequencer
//
// Register-select unit for the processor datapath. It replaces the purely
// combinational register decoder in the control path with:
//   - a registered one-hot read select that drives the bus (1 cycle latency),
//   - a timed one-hot write-enable strobe, run by a small write FSM under a
//     four-phase req/ack handshake,
//   - flags for invalid/protected write addresses and read/write collisions.
//
// Decode rule: address a with 1 <= a <= NUM_REGS sets bit (NUM_REGS - a), so
// address 1 is the MSB. Address 0 and a > NUM_REGS decode to all-zero.
//
// Optional build macro: REG_SEL_WPROT_EN
//   Defined   -> adds input wprot_mask; a write whose decoded one-hot hits a
//                set mask bit is rejected like an invalid address.
//   Undefined -> no wprot_mask port; every valid address is writable.
//
// Parameters:
//   NUM_REGS       number of addressable registers (one-hot width),
//                  NUM_REGS <= 2**ADDR_W - 1
//   ADDR_W         address width
//   STROBE_CYCLES  cycles wr_en is held per write (1..15)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   rd_addr    in   register address driving the bus
//   wr_addr    in   register address to write, sampled with wr_req in IDLE
//   wr_req     in   write request (four-phase)
//   wprot_mask in   per-register write protect (REG_SEL_WPROT_EN only)
//   wr_ack     out  write complete / acknowledge
//   wr_busy    out  write FSM not IDLE
//   rd_sel     out  registered one-hot read select
//   wr_en      out  one-hot write-enable strobe
//   addr_err   out  last write rejected (invalid or protected), valid with wr_ack
//   rw_hazard  out  rd_sel and wr_en select the same register this cycle
//   dbg_state  out  write FSM state (00 IDLE, 01 STROBE, 10 ACK)
//
// Handshake (four-phase): the requester raises wr_req with wr_addr stable;
// the unit samples both only in IDLE, performs the strobe, then raises
// wr_ack (with addr_err). The requester drops wr_req; the unit drops wr_ack
// on the edge that samples wr_req=0 and returns to IDLE. A new request is
// taken only from IDLE, so there is at least one IDLE cycle between writes.
module reg_sel_sequencer #(
  parameter int NUM_REGS      = 14,
  parameter int ADDR_W        = 4,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                wr_req,
`ifdef REG_SEL_WPROT_EN
  input  logic [NUM_REGS-1:0] wprot_mask,
`endif
  output logic                wr_ack,
  output logic                wr_busy,
  output logic [NUM_REGS-1:0] rd_sel,
  output logic [NUM_REGS-1:0] wr_en,
  output logic                addr_err,
  output logic                rw_hazard,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(a) == (NUM_REGS - i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic [1:0]          r_state;
  logic [3:0]          r_cnt;
  logic [NUM_REGS-1:0] r_rd_sel;
  logic [NUM_REGS-1:0] r_wr_en;
  logic                r_err;
  logic                r_hazard;

  logic [1:0]          w_state_nxt;
  logic [3:0]          w_cnt_nxt;
  logic [NUM_REGS-1:0] w_rd_sel_nxt;
  logic [NUM_REGS-1:0] w_wr_en_nxt;
  logic                w_err_nxt;
  logic [NUM_REGS-1:0] w_wr_dec;
  logic                w_wr_ok;

  assign w_rd_sel_nxt = decode(rd_addr);
  assign w_wr_dec     = decode(wr_addr);

  // An all-zero decode means the address is out of range.
`ifdef REG_SEL_WPROT_EN
  assign w_wr_ok = (|w_wr_dec) && !(|(w_wr_dec & wprot_mask));
`else
  assign w_wr_ok = |w_wr_dec;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en_nxt = r_wr_en;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (wr_req) begin
          if (w_wr_ok) begin
            // The decoded one-hot is the latched write address; later
            // wr_addr changes cannot disturb the strobe.
            w_state_nxt = ST_STROBE;
            w_wr_en_nxt = w_wr_dec;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = ST_ACK;
            w_err_nxt   = 1'b1;
          end
        end
      end
      ST_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_wr_en_nxt = '0;
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ACK: begin
        if (!wr_req) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
        w_wr_en_nxt = '0;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_rd_sel <= '0;
      r_wr_en  <= '0;
      r_err    <= 1'b0;
      r_hazard <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_sel <= w_rd_sel_nxt;
      r_wr_en  <= w_wr_en_nxt;
      r_err    <= w_err_nxt;
      // Computed from next-state values so the flag lines up with the
      // registered rd_sel/wr_en it describes.
      r_hazard <= |(w_rd_sel_nxt & w_wr_en_nxt);
    end
  end

  assign rd_sel    = r_rd_sel;
  assign wr_en     = r_wr_en;
  assign wr_ack    = (r_state == ST_ACK);
  assign wr_busy   = (r_state != ST_IDLE);
  assign addr_err  = r_err;
  assign rw_hazard = r_hazard;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_sel_sequencer.sv
// Testbench for reg_sel_sequencer. Two instances share one stimulus stream:
// u_dut1 with STROBE_CYCLES=1 and u_dut3 with STROBE_CYCLES=3.
module tb_reg_sel_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  rd_addr;
  logic [3:0]  wr_addr;
  logic        wr_req;
`ifdef REG_SEL_WPROT_EN
  logic [13:0] wprot_mask;
`endif

  logic        wr_ack1, wr_busy1, addr_err1, rw_hazard1;
  logic [13:0] rd_sel1, wr_en1;
  logic [1:0]  dbg_state1;
  logic        wr_ack3, wr_busy3, addr_err3, rw_hazard3;
  logic [13:0] rd_sel3, wr_en3;
  logic [1:0]  dbg_state3;

  int checks = 0;
  int errors = 0;

  reg_sel_sequencer #(.NUM_REGS(14), .ADDR_W(4), .STROBE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_req(wr_req),
`ifdef REG_SEL_WPROT_EN
    .wprot_mask(wprot_mask),
`endif
    .wr_ack(wr_ack1), .wr_busy(wr_busy1), .rd_sel(rd_sel1), .wr_en(wr_en1),
    .addr_err(addr_err1), .rw_hazard(rw_hazard1), .dbg_state(dbg_state1)
  );

  reg_sel_sequencer #(.NUM_REGS(14), .ADDR_W(4), .STROBE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_req(wr_req),
`ifdef REG_SEL_WPROT_EN
    .wprot_mask(wprot_mask),
`endif
    .wr_ack(wr_ack3), .wr_busy(wr_busy3), .rd_sel(rd_sel3), .wr_en(wr_en3),
    .addr_err(addr_err3), .rw_hazard(rw_hazard3), .dbg_state(dbg_state3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop the request and wait (bounded) for both FSMs to return to IDLE.
  task automatic drain();
    wr_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!wr_busy1 && !wr_busy3) break;
      tick();
    end
    checks++;
    if (wr_busy1 || wr_busy3) begin
      errors++;
      $display("FAIL drain_timeout busy1=%0b busy3=%0b required 0/0", wr_busy1, wr_busy3);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    rd_addr = 4'd0;
    wr_addr = 4'd0;
    wr_req  = 1'b0;
`ifdef REG_SEL_WPROT_EN
    wprot_mask = 14'd0;
`endif
    tick();
    tick();
    checks++;
    if ({wr_ack1, wr_busy1, addr_err1, rw_hazard1, rd_sel1, wr_en1} !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs_dut1 got ack=%0b busy=%0b err=%0b haz=%0b rd=%b wr=%b required all 0",
               wr_ack1, wr_busy1, addr_err1, rw_hazard1, rd_sel1, wr_en1);
    end
    checks++;
    if ({wr_ack3, wr_busy3, addr_err3, rw_hazard3, rd_sel3, wr_en3} !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs_dut3 got ack=%0b busy=%0b err=%0b haz=%0b rd=%b wr=%b required all 0",
               wr_ack3, wr_busy3, addr_err3, rw_hazard3, rd_sel3, wr_en3);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_sweep();
    logic [13:0] exp;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      exp = (a >= 1 && a <= 14) ? (14'd1 << (14 - a)) : 14'd0;
      checks++;
      if (rd_sel1 !== exp) begin
        errors++;
        $display("FAIL read_sweep addr=%0d got %b required %b", a, rd_sel1, exp);
      end
      if (a == 1) begin
        checks++;
        if (rd_sel1 !== 14'b10000000000000) begin
          errors++;
          $display("FAIL read_addr1_msb got %b required %b", rd_sel1, 14'b10000000000000);
        end
      end
      if (a == 14) begin
        checks++;
        if (rd_sel3 !== 14'b00000000000001) begin
          errors++;
          $display("FAIL read_addr14_lsb got %b required %b", rd_sel3, 14'b00000000000001);
        end
      end
    end
    rd_addr = 4'd0;
    tick();
  endtask

  task automatic test_basic_write();
    wr_addr = 4'b1011;
    wr_req  = 1'b1;
    tick();  // edge N
    checks++;
    if (wr_en1 !== 14'b00000000001000 || wr_busy1 !== 1'b1 || wr_ack1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_strobe got wr_en=%b busy=%0b ack=%0b required 00000000001000/1/0",
               wr_en1, wr_busy1, wr_ack1);
    end
    tick();  // edge N+1
    checks++;
    if (wr_en1 !== 14'd0 || wr_ack1 !== 1'b1 || addr_err1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack got wr_en=%b ack=%0b err=%0b required 0/1/0", wr_en1, wr_ack1, addr_err1);
    end
    tick();
    tick();
    checks++;
    if (wr_ack1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack_hold got %0b required 1", wr_ack1);
    end
    wr_req = 1'b0;
    tick();
    checks++;
    if (wr_ack1 !== 1'b0 || wr_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got ack=%0b busy=%0b required 0/0", wr_ack1, wr_busy1);
    end
    drain();
  endtask

  task automatic test_strobe_len();
    wr_addr = 4'b0001;
    wr_req  = 1'b1;
    tick();
    wr_addr = 4'b0010;  // must not affect the running strobe
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (wr_en3 !== 14'b10000000000000 || wr_ack3 !== 1'b0) begin
        errors++;
        $display("FAIL strobe3_cycle%0d got wr_en=%b ack=%0b required 10000000000000/0", c, wr_en3, wr_ack3);
      end
      tick();
    end
    checks++;
    if (wr_en3 !== 14'd0 || wr_ack3 !== 1'b1) begin
      errors++;
      $display("FAIL strobe3_end got wr_en=%b ack=%0b required 0/1", wr_en3, wr_ack3);
    end
    wr_req = 1'b0;
    tick();
    checks++;
    if (wr_ack3 !== 1'b0 || dbg_state3 !== 2'b00) begin
      errors++;
      $display("FAIL strobe3_release got ack=%0b state=%0d required 0/0", wr_ack3, dbg_state3);
    end
    drain();
  endtask

  task automatic test_invalid();
    logic [3:0] bad [2];
    bad[0] = 4'b1111;
    bad[1] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      wr_addr = bad[k];
      wr_req  = 1'b1;
      tick();
      checks++;
      if (wr_en1 !== 14'd0 || wr_ack1 !== 1'b1 || addr_err1 !== 1'b1 ||
          wr_en3 !== 14'd0 || wr_ack3 !== 1'b1 || addr_err3 !== 1'b1) begin
        errors++;
        $display("FAIL invalid_addr%0d got wr_en=%b/%b ack=%0b/%0b err=%0b/%0b required 0/0 1/1 1/1",
                 bad[k], wr_en1, wr_en3, wr_ack1, wr_ack3, addr_err1, addr_err3);
      end
      wr_req = 1'b0;
      tick();
      checks++;
      if (wr_ack1 !== 1'b0 || addr_err1 !== 1'b0) begin
        errors++;
        $display("FAIL invalid_release got ack=%0b err=%0b required 0/0", wr_ack1, addr_err1);
      end
      drain();
    end
  endtask

`ifdef REG_SEL_WPROT_EN
  task automatic test_wprot();
    wprot_mask = 14'b00000000001000;  // protect address 11
    wr_addr = 4'd11;
    wr_req  = 1'b1;
    tick();
    checks++;
    if (wr_en1 !== 14'd0 || wr_ack1 !== 1'b1 || addr_err1 !== 1'b1) begin
      errors++;
      $display("FAIL wprot_reject got wr_en=%b ack=%0b err=%0b required 0/1/1", wr_en1, wr_ack1, addr_err1);
    end
    drain();
    wr_addr = 4'd10;
    wr_req  = 1'b1;
    tick();
    checks++;
    if (wr_en1 !== 14'b00000000010000) begin
      errors++;
      $display("FAIL wprot_allow got %b required 00000000010000", wr_en1);
    end
    drain();
    wprot_mask = 14'd0;
  endtask
`endif

  task automatic test_hazard();
    rd_addr = 4'b1010;
    tick();
    checks++;
    if (rw_hazard1 !== 1'b0 || rw_hazard3 !== 1'b0) begin
      errors++;
      $display("FAIL hazard_idle got %0b/%0b required 0/0", rw_hazard1, rw_hazard3);
    end
    wr_addr = 4'b1010;
    wr_req  = 1'b1;
    tick();
    checks++;
    if (rw_hazard1 !== 1'b1 || wr_en1 !== 14'b00000000010000 || rd_sel1 !== 14'b00000000010000) begin
      errors++;
      $display("FAIL hazard_strobe got haz=%0b wr_en=%b rd_sel=%b required 1/00000000010000/00000000010000",
               rw_hazard1, wr_en1, rd_sel1);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (rw_hazard3 !== (c <= 3)) begin
        errors++;
        $display("FAIL hazard3_cycle%0d got %0b required %0b", c, rw_hazard3, (c <= 3));
      end
      tick();
      if (c == 1) begin
        checks++;
        if (rw_hazard1 !== 1'b0) begin
          errors++;
          $display("FAIL hazard_after_strobe got %0b required 0", rw_hazard1);
        end
      end
    end
    drain();
    // Write to a different register while reading 10: no hazard.
    wr_addr = 4'b0011;
    wr_req  = 1'b1;
    tick();
    checks++;
    if (rw_hazard1 !== 1'b0 || wr_en1 !== 14'b00100000000000) begin
      errors++;
      $display("FAIL hazard_distinct got haz=%0b wr_en=%b required 0/00100000000000", rw_hazard1, wr_en1);
    end
    drain();
    rd_addr = 4'd0;
  endtask

  task automatic test_reset_mid_strobe();
    wr_addr = 4'b0101;
    wr_req  = 1'b1;
    tick();
    checks++;
    if (wr_en3 !== 14'b00001000000000 || wr_busy3 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got wr_en=%b busy=%0b required 00001000000000/1", wr_en3, wr_busy3);
    end
    #2;
    reset  = 1'b1;
    wr_req = 1'b0;
    #1;  // no clock edge in between: clear must be asynchronous
    checks++;
    if (wr_en3 !== 14'd0 || wr_ack3 !== 1'b0 || wr_busy3 !== 1'b0 ||
        wr_en1 !== 14'd0 || wr_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got wr_en3=%b ack3=%0b busy3=%0b wr_en1=%b busy1=%0b required all 0",
               wr_en3, wr_ack3, wr_busy3, wr_en1, wr_busy1);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (wr_ack3 !== 1'b0 || dbg_state3 !== 2'b00 || wr_en3 !== 14'd0) begin
        errors++;
        $display("FAIL midreset_after%0d got ack=%0b state=%0d wr_en=%b required 0/0/0",
                 c, wr_ack3, dbg_state3, wr_en3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_sweep();
    test_basic_write();
    test_strobe_len();
    test_invalid();
`ifdef REG_SEL_WPROT_EN
    test_wprot();
`endif
    test_hazard();
    test_reset_mid_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
